// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell plus a carry flop, one bit per clock, LSB first.
// Result and carry-out are registered and announced by a one-cycle done pulse.

module f_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_adder #(
    parameter int  N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   shift_a_q, shift_a_d;
    logic [N-1:0]   shift_b_q, shift_b_d;
    logic [N-1:0]   acc_q, acc_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    logic           s_bit_s;
    logic           c_next_s;
    logic [N-1:0]   acc_shift_s;

    f_adder u_fa (
        .a    (shift_a_q[0]),
        .b    (shift_b_q[0]),
        .cin  (carry_q),
        .s    (s_bit_s),
        .cout (c_next_s)
    );

    // New sum bit enters at the MSB so that after N steps bit 0 holds the first-computed bit.
    assign acc_shift_s = (acc_q >> 1'b1) | (N'(s_bit_s) << (N - 1));

    // Next-state and datapath update for the IDLE/RUN sequencer.
    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_a_d = a;
                    shift_b_d = b;
                    carry_d   = cin;
                    cnt_d     = {CW{1'b0}};
                    state_d   = RUN;
                    busy_d    = 1'b1;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            RUN: begin
                shift_a_d = shift_a_q >> 1'b1;
                shift_b_d = shift_b_q >> 1'b1;
                acc_d     = acc_shift_s;
                carry_d   = c_next_s;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    sum_d   = acc_shift_s;
                    cout_d  = c_next_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any addition in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_a_q <= {N{1'b0}};
            shift_b_q <= {N{1'b0}};
            acc_q     <= {N{1'b0}};
            carry_q   <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            sum_q     <= {N{1'b0}};
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases with literal results plus random traffic
// compared every cycle against an arithmetic model of the add-with-latency behaviour.

module tb_serial_adder;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    int total;
    int bad;
    int cyc;

    serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: an accepted start schedules a+b+cin to appear N edges later.
    int           m_rem;
    logic [N:0]   m_pend;
    logic [N-1:0] m_sum;
    logic         m_cout;
    logic         m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_pend <= '0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    m_pend <= {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
                    m_rem  <= N;
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_sum  <= m_pend[N-1:0];
                    m_cout <= m_pend[N];
                    m_done <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(m_rem != 0));
            chk("done", 32'(done), 32'(m_done));
            chk("sum",  32'(sum),  32'(m_sum));
            chk("cout", 32'(cout), 32'(m_cout));
        end else begin
            chk("rst_outs", {22'd0, busy, done, sum}, 32'd0);
            chk("rst_cout", 32'(cout), 32'd0);
        end
    end

    task automatic wait_done(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3 * N; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, 3 * N);
        end
    endtask

    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc,
                          input logic [N-1:0] es, input logic ec, input string name);
        @(posedge clk);
        #1;
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(name);
        chk({name, "_sum"},  32'(sum),  32'(es));
        chk({name, "_cout"}, 32'(cout), 32'(ec));
    endtask

    int d1;
    int d2;

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #3;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ripple");
        run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_c1");
        run_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, "a5_c0");

        // start held through RUN: ignored while busy, then accepted in the done cycle
        @(posedge clk);
        #1;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'hEE; b = 8'hEE;
        wait_done("held1");
        chk("held1_sum",  32'(sum),  32'h46);
        chk("held1_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("held2");
        chk("held2_sum",  32'(sum),  32'hDC);
        chk("held2_cout", 32'(cout), 32'd1);

        // back-to-back: next start presented during the done cycle
        @(posedge clk);
        #1;
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b1");
        d1 = cyc;
        chk("b2b1_sum",  32'(sum),  32'h00);
        chk("b2b1_cout", 32'(cout), 32'd1);
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b2");
        d2 = cyc;
        chk("b2b2_sum",  32'(sum),  32'h80);
        chk("b2b2_cout", 32'(cout), 32'd0);
        chk("b2b_spacing", 32'(d2 - d1), 32'(N + 1));

        // asynchronous reset after the third RUN edge
        @(posedge clk);
        #1;
        a = 8'hC3; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum",  32'(sum),  32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 2) @(negedge clk);
        run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after_rst");

        // random traffic, including starts while busy
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 3) == 0);
            a     = N'($urandom);
            b     = N'($urandom);
            cin   = 1'($urandom);
        end
        start = 1'b0;
        repeat (N + 3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
